// File: rtl/mips_cpu_if.sv
// rtl/mips_cpu_if.sv - program and data bus bundle between mips_cpu and its memories
interface mips_cpu_if;
    logic [31:0] Prog_BUS_READ;
    logic [31:0] Data_BUS_READ;
    logic [31:0] ADDR_Prog;
    logic        CS_P;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic        CS;
    logic        WR_RD;

    modport master (
        input  Prog_BUS_READ, Data_BUS_READ,
        output ADDR_Prog, CS_P, ADDR, Data_BUS_WRITE, CS, WR_RD
    );

    modport slave (
        output Prog_BUS_READ, Data_BUS_READ,
        input  ADDR_Prog, CS_P, ADDR, Data_BUS_WRITE, CS, WR_RD
    );
endinterface

// File: rtl/mips_cpu.sv
// rtl/mips_cpu.sv - five-stage MIPS-subset core, pipeline advances once per 34-clock tick
module mips_cpu (
    input  logic       CLK_SYS,
    input  logic       RST,
    mips_cpu_if.master bus
);
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;
    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;

    logic [5:0]  count;
    logic        tick;
    logic [31:0] pc, ifid_instr;
    logic [31:0] rf [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, d_dest;
    logic [31:0] imm_sext, rs_val, rt_val;
    logic        d_we, d_use_imm, d_lw, d_sw, d_mul;
    alu_op_t     d_alu;

    logic        idex_we, idex_use_imm, idex_lw, idex_sw, idex_mul;
    logic [4:0]  idex_dest;
    alu_op_t     idex_alu;
    logic [31:0] idex_a, idex_b, idex_imm, ex_op2, ex_alu, ex_result;

    logic        exmem_we, exmem_lw, exmem_sw, cs;
    logic [4:0]  exmem_dest;
    logic [31:0] exmem_result, exmem_wdata;

    logic        memwb_we, memwb_lw, wb_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result, memwb_load, write_back;

    mul_state_t  mul_state, mul_state_n;
    logic [4:0]  mul_cnt;
    logic [31:0] mul_mcand, mul_mplier, mul_acc;
    logic        mul_start, mul_done;

    assign tick = (count == 6'd33);

    always_ff @(posedge CLK_SYS) begin
        if (RST || tick) count <= '0;
        else             count <= count + 6'd1;
    end

    assign op       = ifid_instr[31:26];
    assign rs       = ifid_instr[25:21];
    assign rt       = ifid_instr[20:16];
    assign rd       = ifid_instr[15:11];
    assign shamt    = ifid_instr[10:6];
    assign funct    = ifid_instr[5:0];
    assign imm_sext = {{16{ifid_instr[15]}}, ifid_instr[15:0]};

    // Anything not matched below stays a NOP: no write, no bus access.
    always_comb begin
        d_we = 1'b0; d_use_imm = 1'b0; d_lw = 1'b0; d_sw = 1'b0; d_mul = 1'b0;
        d_dest = rd; d_alu = ALU_ADD;
        case (op)
            6'h00: if (shamt == 5'd0) begin
                case (funct)
                    6'h20: begin d_we = 1'b1; d_alu = ALU_ADD; end
                    6'h22: begin d_we = 1'b1; d_alu = ALU_SUB; end
                    6'h24: begin d_we = 1'b1; d_alu = ALU_AND; end
                    6'h25: begin d_we = 1'b1; d_alu = ALU_OR;  end
                    default: ;
                endcase
            end
            6'h1C: if (shamt == 5'd0 && funct == 6'h02) begin
                d_we = 1'b1; d_mul = 1'b1;
            end
            6'h08: begin d_we = 1'b1; d_use_imm = 1'b1; d_dest = rt; end
            6'h23: begin d_we = 1'b1; d_use_imm = 1'b1; d_dest = rt; d_lw = 1'b1; end
            6'h2B: begin d_use_imm = 1'b1; d_sw = 1'b1; end
            default: ;
        endcase
    end

    assign wb_write   = memwb_we && (memwb_rd != 5'd0);
    assign write_back = memwb_lw ? memwb_load : memwb_result;

    // Write-through register file: the WB value is visible to ID in the same slot.
    always_comb begin
        rs_val = rf[rs];
        rt_val = rf[rt];
        if (rs == 5'd0)                     rs_val = '0;
        else if (wb_write && memwb_rd == rs) rs_val = write_back;
        if (rt == 5'd0)                     rt_val = '0;
        else if (wb_write && memwb_rd == rt) rt_val = write_back;
    end

    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (tick && wb_write) begin
            rf[memwb_rd] <= write_back;
        end
    end

    always_comb begin
        ex_op2 = idex_use_imm ? idex_imm : idex_b;
        ex_alu = idex_a + ex_op2;
        case (idex_alu)
            ALU_SUB: ex_alu = idex_a - ex_op2;
            ALU_AND: ex_alu = idex_a & ex_op2;
            ALU_OR:  ex_alu = idex_a | ex_op2;
            default: ex_alu = idex_a + ex_op2;
        endcase
        ex_result = idex_mul ? (mul_done ? mul_acc : '0) : ex_alu;
    end

    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            pc <= '0; ifid_instr <= '0;
            idex_we <= 1'b0; idex_use_imm <= 1'b0; idex_lw <= 1'b0; idex_sw <= 1'b0;
            idex_mul <= 1'b0; idex_dest <= '0; idex_alu <= ALU_ADD;
            idex_a <= '0; idex_b <= '0; idex_imm <= '0;
            exmem_we <= 1'b0; exmem_lw <= 1'b0; exmem_sw <= 1'b0; exmem_dest <= '0;
            exmem_result <= '0; exmem_wdata <= '0;
            memwb_we <= 1'b0; memwb_lw <= 1'b0; memwb_rd <= '0;
            memwb_result <= '0; memwb_load <= '0;
        end else if (tick) begin
            pc           <= pc + 32'd4;
            ifid_instr   <= bus.Prog_BUS_READ;
            idex_we      <= d_we;
            idex_use_imm <= d_use_imm;
            idex_lw      <= d_lw;
            idex_sw      <= d_sw;
            idex_mul     <= d_mul;
            idex_dest    <= d_dest;
            idex_alu     <= d_alu;
            idex_a       <= rs_val;
            idex_b       <= rt_val;
            idex_imm     <= imm_sext;
            exmem_we     <= idex_we;
            exmem_lw     <= idex_lw;
            exmem_sw     <= idex_sw;
            exmem_dest   <= idex_dest;
            exmem_result <= ex_result;
            exmem_wdata  <= idex_b;
            memwb_we     <= exmem_we;
            memwb_lw     <= exmem_lw;
            memwb_rd     <= exmem_dest;
            memwb_result <= exmem_result;
            memwb_load   <= bus.Data_BUS_READ;
        end
    end

    assign mul_start = tick && d_mul;
    assign mul_done  = (mul_state == MUL_DONE);

    always_ff @(posedge CLK_SYS) begin
        if (RST) mul_state <= MUL_IDLE;
        else     mul_state <= mul_state_n;
    end

    always_comb begin
        mul_state_n = mul_state;
        case (mul_state)
            MUL_RUN: if (mul_cnt == 5'd31) mul_state_n = MUL_DONE;
            default: if (mul_start)        mul_state_n = MUL_RUN;
        endcase
    end

    // One shift-add step per clock; 32 steps finish two clocks ahead of the next tick.
    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            mul_mcand <= '0; mul_mplier <= '0; mul_acc <= '0; mul_cnt <= '0;
        end else if (mul_start) begin
            mul_mcand <= rs_val; mul_mplier <= rt_val; mul_acc <= '0; mul_cnt <= '0;
        end else if (mul_state == MUL_RUN) begin
            if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + 5'd1;
        end
    end

    assign cs                 = exmem_lw | exmem_sw;
    assign bus.CS             = cs;
    assign bus.WR_RD          = exmem_sw;
    assign bus.ADDR           = cs ? exmem_result : '0;
    assign bus.Data_BUS_WRITE = exmem_sw ? exmem_wdata : '0;
    assign bus.ADDR_Prog      = pc;
    assign bus.CS_P           = ~RST;
endmodule

// File: tb/tb_mips_cpu.sv
// tb/tb_mips_cpu.sv - scoreboard bench for mips_cpu writeback and data-bus traffic
module tb_mips_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_cpu_if bus ();
    mips_cpu dut (.CLK_SYS(clk), .RST(rst), .bus(bus));

    logic [31:0] prog [64];
    logic [31:0] dmem [64];
    assign bus.Prog_BUS_READ = prog[bus.ADDR_Prog[7:2]];
    assign bus.Data_BUS_READ = dmem[bus.ADDR[7:2]];

    typedef struct { logic [4:0] rd; logic [31:0] val; } wb_exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } bus_exp_t;
    wb_exp_t  wb_q [$];
    bus_exp_t bus_q [$];
    wb_exp_t  wb_e;
    bus_exp_t bus_e;

    int checks = 0;
    int failures = 0;
    int bcnt = 0;
    int cs_len = 0;
    bit cs_prev = 1'b0;
    bit mon_en = 1'b0;
    bit seen;

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [4:0] rd, logic [5:0] fn);
        return {op, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic push_wb(logic [4:0] rd, logic [31:0] v);
        wb_q.push_back('{rd: rd, val: v});
    endtask

    task automatic push_bus(logic we, logic [31:0] a, logic [31:0] d);
        bus_q.push_back('{we: we, addr: a, data: d});
    endtask

    task automatic check_idle(string tag);
        check_val({tag, "_addr_prog"}, bus.ADDR_Prog, 32'd0);
        check_val({tag, "_cs_p"}, {31'd0, bus.CS_P}, 32'd0);
        check_val({tag, "_addr"}, bus.ADDR, 32'd0);
        check_val({tag, "_wdata"}, bus.Data_BUS_WRITE, 32'd0);
        check_val({tag, "_cs"}, {31'd0, bus.CS}, 32'd0);
        check_val({tag, "_wr_rd"}, {31'd0, bus.WR_RD}, 32'd0);
    endtask

    always @(posedge clk) begin
        if (rst) bcnt <= 0;
        else     bcnt <= (bcnt == 33) ? 0 : bcnt + 1;
    end

    // bcnt==33 at a falling edge means the next rising edge is a tick.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bcnt == 33 && dut.memwb_we && dut.memwb_rd != 5'd0) begin
                if (wb_q.size() == 0) begin
                    check_val("wb_unexpected_rd", {27'd0, dut.memwb_rd}, 32'd0);
                end else begin
                    wb_e = wb_q.pop_front();
                    check_val("wb_rd", {27'd0, dut.memwb_rd}, {27'd0, wb_e.rd});
                    check_val("wb_val", dut.write_back, wb_e.val);
                end
            end
            if (bcnt == 33 && dut.idex_mul)
                check_val("mul_ready_before_tick", {31'd0, dut.mul_done}, 32'd1);
            if (bus.CS && !cs_prev) begin
                cs_len = 1;
                if (bus_q.size() == 0) begin
                    check_val("bus_unexpected_cs", {31'd0, bus.CS}, 32'd0);
                end else begin
                    bus_e = bus_q.pop_front();
                    check_val("bus_wr_rd", {31'd0, bus.WR_RD}, {31'd0, bus_e.we});
                    check_val("bus_addr", bus.ADDR, bus_e.addr);
                    check_val("bus_wdata", bus.Data_BUS_WRITE, bus_e.data);
                end
            end else if (bus.CS) begin
                cs_len++;
            end else if (cs_prev) begin
                check_val("cs_len", cs_len, 32'd34);
            end
            if (bus.CS && bus.WR_RD && bcnt == 33) dmem[bus.ADDR[7:2]] = bus.Data_BUS_WRITE;
            cs_prev = bus.CS;
        end else begin
            cs_prev = 1'b0;
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) begin prog[i] = 32'd0; dmem[i] = 32'd0; end
        dmem[3] = 32'hCAFEF00D;

        // Reset held for 5 clocks
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_idle("reset");

        prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);              push_wb(5'd1, 32'd5);
        prog[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd3);              push_wb(5'd2, 32'd3);
        prog[4]  = enc_r(6'h00, 5'd1, 5'd2, 5'd3, 6'h20);        push_wb(5'd3, 32'd8);
        prog[5]  = enc_r(6'h00, 5'd1, 5'd2, 5'd4, 6'h22);        push_wb(5'd4, 32'd2);
        prog[6]  = enc_r(6'h00, 5'd1, 5'd2, 5'd5, 6'h24);        push_wb(5'd5, 32'd1);
        prog[7]  = enc_r(6'h00, 5'd1, 5'd2, 5'd6, 6'h25);        push_wb(5'd6, 32'd7);
        prog[8]  = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
        prog[9]  = enc_i(6'h08, 5'd0, 5'd7, 16'd7);              push_wb(5'd7, 32'd7);
        prog[10] = enc_i(6'h08, 5'd0, 5'd8, 16'd6);              push_wb(5'd8, 32'd6);
        prog[11] = enc_i(6'h08, 5'd0, 5'd9, 16'hFFFF);           push_wb(5'd9, 32'hFFFFFFFF);
        prog[12] = enc_i(6'h08, 5'd0, 5'd10, 16'd2);             push_wb(5'd10, 32'd2);
        prog[13] = enc_r(6'h00, 5'd0, 5'd1, 5'd13, 6'h20);       push_wb(5'd13, 32'd5);
        prog[14] = enc_r(6'h1C, 5'd7, 5'd8, 5'd11, 6'h02);       push_wb(5'd11, 32'd42);
        prog[15] = enc_r(6'h1C, 5'd9, 5'd10, 5'd12, 6'h02);      push_wb(5'd12, 32'hFFFFFFFE);
        prog[17] = enc_i(6'h2B, 5'd0, 5'd11, 16'd8);             push_bus(1'b1, 32'd8, 32'd42);
        prog[19] = enc_i(6'h23, 5'd0, 5'd14, 16'd8);             push_bus(1'b0, 32'd8, 32'd0);
                                                                 push_wb(5'd14, 32'd42);
        prog[20] = enc_i(6'h08, 5'd0, 5'd15, 16'd16);            push_wb(5'd15, 32'd16);
        prog[23] = enc_i(6'h23, 5'd15, 5'd16, 16'hFFFC);         push_bus(1'b0, 32'd12, 32'd0);
                                                                 push_wb(5'd16, 32'hCAFEF00D);
        prog[24] = 32'hFC22_1820;
        prog[25] = enc_i(6'h08, 5'd0, 5'd17, 16'h0055);          push_wb(5'd17, 32'h55);
        prog[28] = enc_r(6'h00, 5'd17, 5'd0, 5'd18, 6'h20);      push_wb(5'd18, 32'h55);
        prog[31] = enc_i(6'h2B, 5'd0, 5'd18, 16'd16);            push_bus(1'b1, 32'd16, 32'h55);

        mon_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check_val("cs_p_after_release", {31'd0, bus.CS_P}, 32'd1);
        check_val("pc_after_release", bus.ADDR_Prog, 32'd0);
        repeat (32) @(negedge clk);
        check_val("pc_before_tick1", bus.ADDR_Prog, 32'd0);
        @(negedge clk);
        check_val("pc_after_tick1", bus.ADDR_Prog, 32'd4);
        repeat (33) @(negedge clk);
        check_val("pc_before_tick2", bus.ADDR_Prog, 32'd4);
        @(negedge clk);
        check_val("pc_after_tick2", bus.ADDR_Prog, 32'd8);

        for (int i = 0; i < 1600; i++) begin
            if (wb_q.size() == 0 && bus_q.size() == 0) break;
            @(negedge clk);
        end
        repeat (102) @(negedge clk);
        check_val("wb_queue_drained", wb_q.size(), 32'd0);
        check_val("bus_queue_drained", bus_q.size(), 32'd0);
        check_val("sw_stored_dmem", dmem[4], 32'h55);

        // Reset in the middle of a multiply
        mon_en = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
        prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
        prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd6);
        prog[4] = enc_r(6'h1C, 5'd1, 5'd2, 5'd3, 6'h02);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6 * 34 + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_mid_mul");
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
        mon_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check_val("mul_abort_pc_restart", bus.ADDR_Prog, 32'd0);
        repeat (8 * 34) @(negedge clk);

        // Reset in the middle of a store
        mon_en = 1'b0;
        rst = 1'b1;
        prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h0077);
        prog[3] = enc_i(6'h2B, 5'd0, 5'd1, 16'd20);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 * 34; i++) begin
            @(negedge clk);
            if (bus.CS) begin seen = 1'b1; break; end
        end
        check_val("sw_cs_seen", {31'd0, seen}, 32'd1);
        check_val("sw_addr", bus.ADDR, 32'd20);
        check_val("sw_wdata", bus.Data_BUS_WRITE, 32'h77);
        check_val("sw_wr_rd", {31'd0, bus.WR_RD}, 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_mid_sw");
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
        rst = 1'b0;
        @(negedge clk);
        check_val("sw_abort_pc_restart", bus.ADDR_Prog, 32'd0);
        check_val("sw_abort_cs", {31'd0, bus.CS}, 32'd0);
        check_val("sw_abort_cs_p", {31'd0, bus.CS_P}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_cpu.md
# mips_cpu

Five-stage, in-order MIPS-subset processor core (`cpu`) with separate program and data buses, sitting between an external program memory and an external data memory/peripheral bus. All logic runs on one clock. An internal clock enable ("tick") advances the pipeline once every 34 clock cycles, so a sequential 32-cycle multiplier can finish within one pipeline slot.

## Interface
- No parameters. Tick period is fixed at 34; register file is 32 × 32-bit.
- CLK_SYS  in  1  sole clock, rising-edge, nominal 50 MHz.
- RST  in  1  reset; one clock; reset is synchronous and active-high.
- Prog_BUS_READ  in  32  instruction word for ADDR_Prog.
- Data_BUS_READ  in  32  load data for ADDR.
- ADDR_Prog  out  32  byte address of fetch (PC).
- CS_P  out  1  program memory select.
- ADDR  out  32  data byte address.
- Data_BUS_WRITE  out  32  store data.
- CS  out  1  data memory select.
- WR_RD  out  1  1 = write, 0 = read; meaningful only while CS=1.

## Operation
- Tick counter runs 0..33, wrapping to 0. tick = (count==33). All architectural state (PC, pipeline registers, register file) updates only on clock edges where tick=1. The multiplier FSM is the only logic that advances every clock.
- Stages: IF, ID, EX, MEM, WB. Pipeline registers are IF/ID, ID/EX, EX/MEM and MEM/WB.
  - IF: ADDR_Prog = PC. On tick, latch Prog_BUS_READ into IF/ID and set PC += 4 (wraps modulo 2^32).
  - ID: decode; read rs/rt combinationally. The register file is write-through: a same-tick WB write to the register being read is bypassed.
  - EX: compute the ALU or multiplier result and the effective address.
  - MEM: drive the data bus from EX/MEM; on tick, sample Data_BUS_READ for LW.
  - WB: internal signal writeBack = load data or ALU/MUL result. It is written to rd/rt on tick. Writes to r0 are ignored; r0 always reads 0.
- Supported instructions (standard MIPS encoding):
  - R-type op 0x00: ADD funct 0x20, SUB 0x22, AND 0x24, OR 0x25. Arithmetic is 32-bit wrap; no overflow trap.
  - MUL: op 0x1C, funct 0x02. Result is the low 32 bits of rs × rt.
  - ADDI 0x08: sign-extended imm16.
  - LW 0x23 and SW 0x2B: address = rs + sext(imm16), word aligned; low two address bits are passed through unchecked.
  - Any other encoding, including 0x00000000, executes as a NOP: no write, no bus access.
- Multiplier: starts on the tick that loads ID/EX with a MUL. It uses 32 shift-add iterations, one per clock, and holds the result until the next tick, where it is captured into EX/MEM.
- No hazard detection and no forwarding beyond the register-file bypass. Software must place at least 2 independent instructions between a producer and its consumer. No branches or jumps; the PC is strictly sequential.
- Data bus (registered from EX/MEM, stable for the whole MEM slot):
  - CS=1 iff MEM holds LW or SW.
  - WR_RD=1 for SW.
  - Data_BUS_WRITE = rt value for SW, otherwise 0.
  - ADDR = effective address for LW/SW, otherwise 0.
- CS_P = 1 whenever RST=0.

## Timing
- Reset (sampled at the clock edge):
  - counter = 0, PC = 0, all pipeline registers = NOP, all registers = 0, multiplier idle.
  - Outputs: ADDR_Prog=0, CS_P=0, ADDR=0, Data_BUS_WRITE=0, CS=0, WR_RD=0.
  - RST mid-operation aborts everything, including an in-flight multiply and a bus access. CS drops on the next edge.
- After RST is released, the first tick occurs 34 clocks later. Ticks then occur every 34 clocks.
- An instruction at PC=4k is latched by tick k+1. It is in EX during slot k+2, on the data bus during slot k+3, and in WB during slot k+4. Its register write happens at tick k+5.
- Memories must return data within 33 clocks of the address changing; it is sampled at the tick.
- The multiplier result is valid 32 clocks after the slot starts, before the next tick (34).

## Test plan
- Reset: hold RST for 5 clocks. All outputs must be 0. After release, CS_P=1, ADDR_Prog=0, and ADDR_Prog steps 0→4→8 every 34 clocks.
- ALU: ADDI r1,r0,5; ADDI r2,r0,3; NOP; NOP; ADD r3,r1,r2; SUB r4,r1,r2; AND; OR. writeBack must show 5, 3, 8, 2, 1, 7 in their WB slots.
- MUL: r1=7, r2=6, MUL r3,r1,r2 gives writeBack=42. Also 0xFFFFFFFF×2 gives 0xFFFFFFFE. Check the result is ready before the tick.
- Store/load: SW r3,8(r0) gives CS=1, WR_RD=1, ADDR=8, Data_BUS_WRITE=42 for exactly 34 clocks. LW r5,8(r0) with Data_BUS_READ=42 gives CS=1, WR_RD=0, and writeBack=42. Negative offset: r1=16, LW -4(r1) gives ADDR=12.
- Edge cases: writing r0 leaves it at 0; an undefined opcode produces no write and no CS; same-slot write/read of a register returns the new value via the bypass.
- Reset asserted mid-MUL and mid-SW: outputs go to 0 on the next edge, and the fetch restarts at address 0.
